// File: rtl/seg7_scan_decoder_if.sv
// Multiplexed seven-segment bus as seen by the scan decoder: segment/strobe
// lines in, per-digit decoded values and the update strobe out.
interface seg7_scan_decoder_if #(
  parameter int unsigned DIGITS = 4
);
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [6:0]          seg_in;
  logic [DIGITS-1:0]   dig_in;
  logic [4*DIGITS-1:0] hex_out;
  logic [DIGITS-1:0]   blank_out;
  logic [DIGITS-1:0]   err_out;
  logic                upd;
  logic [IDX_W-1:0]    upd_idx;

  modport master (
    output seg_in, dig_in,
    input  hex_out, blank_out, err_out, upd, upd_idx
  );

  modport slave (
    input  seg_in, dig_in,
    output hex_out, blank_out, err_out, upd, upd_idx
  );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Samples a multiplexed seven-segment bus, waits for each strobe/segment pair
// to settle and decodes it into a per-digit nibble. Define SEG7_SCAN_SYNC_EN
// for a two-flop input synchronizer; otherwise a single input register is used.
module seg7_scan_decoder #(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned STABLE_CYCLES = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  seg7_scan_decoder_if.slave  bus
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  typedef enum logic [1:0] {ST_WAIT, ST_COUNT, ST_HELD} state_e;
  typedef enum logic [1:0] {PAT_HEX, PAT_BLANK, PAT_ERR} pat_kind_e;

  typedef struct packed {
    pat_kind_e  kind;
    logic [3:0] nibble;
  } pat_dec_t;

  function automatic pat_dec_t decode_seg(input logic [6:0] seg);
    pat_dec_t r;
    r.kind   = PAT_HEX;
    r.nibble = 4'h0;
    case (seg)
      7'h7E: r.nibble = 4'h0;
      7'h30: r.nibble = 4'h1;
      7'h6D: r.nibble = 4'h2;
      7'h79: r.nibble = 4'h3;
      7'h33: r.nibble = 4'h4;
      7'h5B: r.nibble = 4'h5;
      7'h5F: r.nibble = 4'h6;
      7'h70: r.nibble = 4'h7;
      7'h7F: r.nibble = 4'h8;
      7'h7B: r.nibble = 4'h9;
      7'h77: r.nibble = 4'hA;
      7'h1F: r.nibble = 4'hB;
      7'h4E: r.nibble = 4'hC;
      7'h3D: r.nibble = 4'hD;
      7'h4F: r.nibble = 4'hE;
      7'h47: r.nibble = 4'hF;
      7'h00: r.kind   = PAT_BLANK;
      default: r.kind = PAT_ERR;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Input stage: produces the sampled pair (s_seg_q, s_dig_q)
  // ---------------------------------------------------------------------------
  logic [6:0]        s_seg_q;
  logic [DIGITS-1:0] s_dig_q;

`ifdef SEG7_SCAN_SYNC_EN
  logic [6:0]        m_seg_q;
  logic [DIGITS-1:0] m_dig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_seg_q <= '0;
      m_dig_q <= '0;
      s_seg_q <= '0;
      s_dig_q <= '0;
    end else begin
      // NOTE: non-blocking so the second flop takes the first flop's old value.
      m_seg_q <= bus.seg_in;
      m_dig_q <= bus.dig_in;
      s_seg_q <= m_seg_q;
      s_dig_q <= m_dig_q;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_seg_q <= '0;
      s_dig_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop updates from pre-edge values.
      s_seg_q <= bus.seg_in;
      s_dig_q <= bus.dig_in;
    end
  end
`endif

  // Previous sampled pair, used to detect any segment or strobe change.
  logic [6:0]        p_seg_q;
  logic [DIGITS-1:0] p_dig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_seg_q <= '0;
      p_dig_q <= '0;
    end else begin
      p_seg_q <= s_seg_q;
      p_dig_q <= s_dig_q;
    end
  end

  logic s_onehot;
  logic s_changed;

  assign s_onehot  = (s_dig_q != '0) && ((s_dig_q & (s_dig_q - 1'b1)) == '0);
  assign s_changed = (s_seg_q != p_seg_q) || (s_dig_q != p_dig_q);

  // ---------------------------------------------------------------------------
  // Settle FSM
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_WAIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;

    case (state_q)
      ST_WAIT: begin
        if (s_onehot) begin
          state_d = ST_COUNT;
          cnt_d   = CNT_ONE;
        end
      end
      ST_COUNT: begin
        if (!s_onehot) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else if (s_changed) begin
          cnt_d = CNT_ONE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HELD: begin
        if (s_changed) begin
          if (s_onehot) begin
            state_d = ST_COUNT;
            cnt_d   = CNT_ONE;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
    endcase

    // Reaching the threshold captures the current (stable) pair exactly once.
    if (state_d == ST_COUNT && cnt_d == CNT_MAX) begin
      capture = 1'b1;
      state_d = ST_HELD;
    end
  end

  // ---------------------------------------------------------------------------
  // Capture into the slot selected by the sampled strobe
  // ---------------------------------------------------------------------------
  pat_dec_t         dec;
  logic [IDX_W-1:0] slot_idx;

  assign dec = decode_seg(s_seg_q);

  always_comb begin
    slot_idx = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (s_dig_q[i]) slot_idx = IDX_W'(i);
    end
  end

  logic [4*DIGITS-1:0] hex_q;
  logic [DIGITS-1:0]   blank_q;
  logic [DIGITS-1:0]   err_q;
  logic                upd_q;
  logic [IDX_W-1:0]    upd_idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the slot array must read 0 straight after reset, so it is reset
      // like any other flop rather than left as uninitialised storage.
      hex_q     <= '0;
      blank_q   <= '0;
      err_q     <= '0;
      upd_q     <= 1'b0;
      upd_idx_q <= '0;
    end else begin
      upd_q <= capture;
      if (capture) upd_idx_q <= slot_idx;
      for (int i = 0; i < int'(DIGITS); i++) begin
        if (capture && s_dig_q[i]) begin
          case (dec.kind)
            PAT_HEX: begin
              hex_q[4*i +: 4] <= dec.nibble;
              blank_q[i]      <= 1'b0;
              err_q[i]        <= 1'b0;
            end
            PAT_BLANK: begin
              hex_q[4*i +: 4] <= 4'h0;
              blank_q[i]      <= 1'b1;
              err_q[i]        <= 1'b0;
            end
            default: begin
              // Illegal pattern keeps the last good nibble and raises the flag.
              blank_q[i] <= 1'b0;
              err_q[i]   <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  assign bus.hex_out   = hex_q;
  assign bus.blank_out = blank_q;
  assign bus.err_out   = err_q;
  assign bus.upd       = upd_q;
  assign bus.upd_idx   = upd_idx_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder (DIGITS=4, STABLE_CYCLES=3); expected
// latency follows SEG7_SCAN_SYNC_EN.
module tb_seg7_scan_decoder;

`ifdef SEG7_SCAN_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif
  localparam int S = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_scan_decoder_if #(.DIGITS(4)) bus ();

  seg7_scan_decoder #(.DIGITS(4), .STABLE_CYCLES(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  // upd is registered on the rising edge, so the falling edge sees it cleanly.
  logic [1:0] upd_log[$];
  always @(negedge clk) begin
    if (bus.upd === 1'b1) upd_log.push_back(bus.upd_idx);
  end

  logic [6:0] pats [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                            7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [3:0] dig, input logic [6:0] seg);
    bus.dig_in = dig;
    bus.seg_in = seg;
  endtask

  task automatic test_reset;
    int first;
    rst_n = 1'b0;
    drive(4'b0001, 7'h7E);
    tick(4);
    n_vec++; if (bus.hex_out !== 16'h0) begin n_err++; $display("FAIL reset_hex got=%h exp=0000", bus.hex_out); end
    n_vec++; if (bus.blank_out !== 4'h0) begin n_err++; $display("FAIL reset_blank got=%b exp=0000", bus.blank_out); end
    n_vec++; if (bus.err_out !== 4'h0) begin n_err++; $display("FAIL reset_err got=%b exp=0000", bus.err_out); end
    n_vec++; if (bus.upd !== 1'b0) begin n_err++; $display("FAIL reset_upd got=%b exp=0", bus.upd); end
    n_vec++; if (bus.upd_idx !== 2'd0) begin n_err++; $display("FAIL reset_upd_idx got=%0d exp=0", bus.upd_idx); end
    rst_n = 1'b1;
    first = 0;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      if (bus.upd === 1'b1 && first == 0) first = k;
    end
    n_vec++; if (first != L + S) begin n_err++; $display("FAIL latency got_edge=%0d exp_edge=%0d", first, L + S); end
    n_vec++; if (bus.upd_idx !== 2'd0) begin n_err++; $display("FAIL latency_idx got=%0d exp=0", bus.upd_idx); end
    n_vec++; if (bus.hex_out !== 16'h0) begin n_err++; $display("FAIL latency_hex got=%h exp=0000", bus.hex_out); end
  endtask

  task automatic test_reset_mid_count;
    upd_log.delete();
    drive(4'b0010, 7'h30);
    tick(2);
    rst_n = 1'b0;
    drive(4'b0000, 7'h00);
    tick(2);
    rst_n = 1'b1;
    tick(10);
    n_vec++; if (upd_log.size() != 0) begin n_err++; $display("FAIL midreset_upd got=%0d exp=0", upd_log.size()); end
    n_vec++; if (bus.hex_out !== 16'h0) begin n_err++; $display("FAIL midreset_hex got=%h exp=0000", bus.hex_out); end
  endtask

  task automatic test_sweep;
    logic [3:0] digs [4];
    logic [6:0] segs [4];
    logic [1:0] idxs [4];
    digs = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    segs = '{7'h47, 7'h3D, 7'h4E, 7'h7B};
    idxs = '{2'd3, 2'd2, 2'd1, 2'd0};
    upd_log.delete();
    for (int d = 0; d < 4; d++) begin
      drive(digs[d], segs[d]);
      tick(6);
    end
    drive(4'b0000, 7'h00);
    tick(3);
    n_vec++; if (bus.hex_out !== 16'hFDC9) begin n_err++; $display("FAIL sweep_hex got=%h exp=fdc9", bus.hex_out); end
    n_vec++; if (bus.blank_out !== 4'h0) begin n_err++; $display("FAIL sweep_blank got=%b exp=0000", bus.blank_out); end
    n_vec++; if (bus.err_out !== 4'h0) begin n_err++; $display("FAIL sweep_err got=%b exp=0000", bus.err_out); end
    n_vec++; if (upd_log.size() != 4) begin n_err++; $display("FAIL sweep_upd_count got=%0d exp=4", upd_log.size()); end
    for (int d = 0; d < 4 && d < upd_log.size(); d++) begin
      n_vec++;
      if (upd_log[d] !== idxs[d]) begin n_err++; $display("FAIL sweep_upd_idx[%0d] got=%0d exp=%0d", d, upd_log[d], idxs[d]); end
    end
  endtask

  task automatic test_blank_illegal;
    logic [6:0]  segs [3];
    logic [15:0] hexs [3];
    logic [3:0]  blks [3];
    logic [3:0]  errs [3];
    segs = '{7'h00, 7'h7F, 7'h01};
    hexs = '{16'hFD09, 16'hFD89, 16'hFD89};
    blks = '{4'b0010, 4'b0000, 4'b0000};
    errs = '{4'b0000, 4'b0000, 4'b0010};
    for (int v = 0; v < 3; v++) begin
      drive(4'b0010, segs[v]);
      tick(6);
      n_vec++; if (bus.hex_out !== hexs[v]) begin n_err++; $display("FAIL blankill_hex[%0d] got=%h exp=%h", v, bus.hex_out, hexs[v]); end
      n_vec++; if (bus.blank_out !== blks[v]) begin n_err++; $display("FAIL blankill_blank[%0d] got=%b exp=%b", v, bus.blank_out, blks[v]); end
      n_vec++; if (bus.err_out !== errs[v]) begin n_err++; $display("FAIL blankill_err[%0d] got=%b exp=%b", v, bus.err_out, errs[v]); end
    end
  endtask

  task automatic test_glitch;
    upd_log.delete();
    drive(4'b0001, 7'h30);
    tick(2);
    drive(4'b0001, 7'h5B);
    tick(8);
    n_vec++; if (upd_log.size() != 1) begin n_err++; $display("FAIL glitch_upd_count got=%0d exp=1", upd_log.size()); end
    n_vec++; if (bus.hex_out !== 16'hFD85) begin n_err++; $display("FAIL glitch_hex got=%h exp=fd85", bus.hex_out); end
    n_vec++; if (bus.upd_idx !== 2'd0) begin n_err++; $display("FAIL glitch_idx got=%0d exp=0", bus.upd_idx); end
  endtask

  task automatic test_illegal_strobes;
    upd_log.delete();
    drive(4'b0011, 7'h7E);
    tick(10);
    drive(4'b0000, 7'h7E);
    tick(10);
    n_vec++; if (upd_log.size() != 0) begin n_err++; $display("FAIL strobe_upd got=%0d exp=0", upd_log.size()); end
    n_vec++; if (bus.hex_out !== 16'hFD85) begin n_err++; $display("FAIL strobe_hex got=%h exp=fd85", bus.hex_out); end
    n_vec++; if (bus.blank_out !== 4'b0000) begin n_err++; $display("FAIL strobe_blank got=%b exp=0000", bus.blank_out); end
    n_vec++; if (bus.err_out !== 4'b0010) begin n_err++; $display("FAIL strobe_err got=%b exp=0010", bus.err_out); end
  endtask

  task automatic test_decode_table;
    for (int n = 0; n < 16; n++) begin
      drive(4'b0100, pats[n]);
      tick(6);
      n_vec++;
      if (bus.hex_out[11:8] !== 4'(n)) begin n_err++; $display("FAIL decode[%h] got=%h exp=%h", pats[n], bus.hex_out[11:8], 4'(n)); end
      n_vec++;
      if ({bus.blank_out[2], bus.err_out[2]} !== 2'b00) begin
        n_err++; $display("FAIL decode_flags[%h] got=%b exp=00", pats[n], {bus.blank_out[2], bus.err_out[2]});
      end
    end
  endtask

  task automatic test_hold_once;
    drive(4'b1000, 7'h33);
    upd_log.delete();
    tick(30);
    n_vec++; if (upd_log.size() != 1) begin n_err++; $display("FAIL hold_upd_count got=%0d exp=1", upd_log.size()); end
    n_vec++; if (bus.hex_out[15:12] !== 4'h4) begin n_err++; $display("FAIL hold_hex got=%h exp=4", bus.hex_out[15:12]); end
  endtask

  initial begin
    drive(4'b0000, 7'h00);
    test_reset();
    test_reset_mid_count();
    test_sweep();
    test_blank_illegal();
    test_glitch();
    test_illegal_strobes();
    test_decode_table();
    test_hold_once();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Receive-side counterpart of the hex-to-seven-segment encoder. It samples a time-multiplexed seven-segment display bus (segment lines plus one-hot digit strobes), waits for each strobe/segment pair to settle, and decodes the pattern back into a hex nibble per digit. Blank and illegal patterns are flagged. It sits on the board-test/loopback path, turning display drive signals back into register-readable values.

## Interface
- `DIGITS`, default 4: number of multiplexed digits (1..8).
- `STABLE_CYCLES`, default 3: number of consecutive identical samples required before a capture (≥1).
- `clk` in 1: single clock; all state on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `seg_in` in 7: segment lines, bit6=a … bit0=g, active high.
- `dig_in` in DIGITS: digit strobes, active high, legal only when exactly one bit is set.
- `hex_out` out 4*DIGITS: decoded nibble per digit; digit i is in bits [4i+3:4i].
- `blank_out` out DIGITS: the last capture for digit i was all segments off.
- `err_out` out DIGITS: the last capture for digit i was a non-hex, non-blank pattern.
- `upd` out 1: one-cycle pulse when a digit slot is written.
- `upd_idx` out clog2(DIGITS) (min 1): index of the slot written; valid while `upd`=1, holds otherwise.

## Operation
- **Input stage.** `seg_in`/`dig_in` are registered into the sampled pair (s_seg, s_dig); stage depth L is set by the macro.
- **Decode map (pattern→nibble).** 7E→0, 30→1, 6D→2, 79→3, 33→4, 5B→5, 5F→6, 70→7, 7F→8, 7B→9, 77→A, 1F→b, 4E→C, 3D→d, 4F→E, 47→F. 00→blank. Any other value→error.
- **FSM states:** WAIT, COUNT, HELD.
  - WAIT: s_dig is not one-hot. Counter is 0. When s_dig becomes one-hot, go to COUNT with counter=1.
  - COUNT: if the pair equals the previous sample, counter increments. If it differs and is still one-hot, counter restarts at 1. If it is not one-hot, go to WAIT. When counter reaches STABLE_CYCLES, capture and go to HELD.
  - HELD: no further capture. Any pair change goes to COUNT (counter=1), or to WAIT if the new pair is not one-hot.
- **Capture into slot i** (the set bit of s_dig):
  - Legal pattern: hex_out[i] ← nibble, blank_out[i] ← 0, err_out[i] ← 0.
  - Blank: hex_out[i] ← 0, blank_out[i] ← 1, err_out[i] ← 0.
  - Illegal: hex_out[i] unchanged, blank_out[i] ← 0, err_out[i] ← 1.
  - Every capture: upd=1 for one cycle, upd_idx=i.
- Each slot keeps its value until it is recaptured. Other slots are never touched.
- Counter saturates and must not wrap. Its width is clog2(STABLE_CYCLES+1).

## Timing
- **Reset:** all outputs 0 (hex_out, blank_out, err_out, upd, upd_idx). FSM goes to WAIT, input registers and counter clear.
- **Reset mid-COUNT:** the pending capture is dropped and no `upd` is produced.
- **Latency:** the inputs change to a legal one-hot pair and then hold. hex_out/flags/upd are updated on the (L+STABLE_CYCLES)th rising edge after the change. With defaults and the macro on, that is edge 5; with the macro off, edge 4.
- A pair that holds forever produces exactly one `upd`.
- **Simultaneous events:**
  - Segment change and strobe change in the same cycle: treated as one pair change.
  - A strobe change on the capture edge: the capture uses the old (stable) pair.
- **STABLE_CYCLES=1:** capture happens on the first sample of each new one-hot pair.
- The scan source must hold each digit for at least STABLE_CYCLES samples, or that digit is never captured.

## Configuration
- `SEG7_SCAN_SYNC_EN` defined: input stage is a two-flop synchronizer (L=2). Use this when the bus is driven from an asynchronous domain or from pins.
- Not defined: input stage is a single register (L=1). Use this for same-clock sources. Latency is one cycle shorter; behaviour is otherwise identical.

## Test plan
- **Reset:** drive rst_n=0 while dig_in=0001 and seg_in=7E are applied. All outputs stay 0. After release, the first `upd` arrives at the edge given by the latency rule.
- **Full sweep:** run a DIGITS=4 scan of digits 3,2,1,0 with patterns 47,3D,4E,7B, each held 6 cycles. Result: hex_out=16'hFDC9, blank_out=0, err_out=0, four `upd` pulses with upd_idx 3,2,1,0.
- **Blank and illegal:** digit 1 gets 00, then digit 1 gets 7F, then digit 1 gets 01.
  - After 00: blank_out[1]=1 and nibble 1 is 0.
  - After 7F: nibble 1 is 8 and both flags are 0.
  - After 01: err_out[1]=1 and nibble 1 stays 8.
- **Glitch rejection:** with STABLE_CYCLES=3, apply a 2-cycle 30 on digit 0, then 5B held. There is no capture of 1; nibble 0 becomes 5 with exactly one `upd`.
- **Illegal strobes:** dig_in=0011 or 0000 for 10 cycles with seg_in=7E. No `upd` and no output change.
- **Both builds:** the latency check runs with and without `SEG7_SCAN_SYNC_EN`. `upd` arrives at edge 5 and edge 4 respectively.
